// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM-stage data-memory access unit.
// Width codes match RV32I funct3 encodings for loads and stores.
package mem_access_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] rv32i_word;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load alignment: picks the byte/half lane by offset and extends per funct3.
// Zero latency, no state, no backpressure.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  rv32i_word   i_rdata,
  output rv32i_word   o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LW:      o_data = i_rdata;
      LBU:     o_data = {24'b0, w_byte};
      LHU:     o_data = {16'b0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: request in IDLE/WAIT, bypass load on resp, buffer it in HOLD until advance.
// Zero-wait resp completes without stall; mem_stall holds upstream until dmem_resp. Optional MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic            advance,
  output logic [XLEN-1:0] dmem_address,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [3:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp,
  output logic [XLEN-1:0] load_data_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic            mem_stall
);

  mem_state_t r_state;
  rv32i_word  r_buf;

  logic       w_access;
  logic       w_mis;
  logic       w_req;
  logic       w_done;
  rv32i_word  w_aligned;
  logic [3:0] w_wmask;
  rv32i_word  w_wdata;

  assign w_access = valid_in & (mem_read_in | mem_write_in);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis = (r_state == IDLE) & w_access &
                 (((funct3_in[1:0] == 2'b01) & addr_in[0]) |
                  ((funct3_in[1:0] == 2'b10) & (addr_in[1:0] != 2'b00)));
`else
  assign w_mis = 1'b0;
`endif

  // WAIT keeps requesting even if valid_in drops: the access must complete.
  assign w_req  = ((r_state == IDLE) & w_access & ~w_mis) | (r_state == WAIT);
  assign w_done = w_req & dmem_resp;

  load_align u_load_align (
    .i_funct3 (funct3_in),
    .i_off    (addr_in[1:0]),
    .i_rdata  (dmem_rdata),
    .o_data   (w_aligned)
  );

  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = '0;
    case (funct3_in)
      SB: begin
        w_wmask = 4'b0001 << addr_in[1:0];
        w_wdata = {24'b0, store_data_in[7:0]} << {addr_in[1:0], 3'b000};
      end
      SH: begin
        w_wmask = addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = addr_in[1] ? {store_data_in[15:0], 16'b0} : {16'b0, store_data_in[15:0]};
      end
      SW: begin
        w_wmask = 4'b1111;
        w_wdata = store_data_in;
      end
      default: begin
        w_wmask = 4'b0000;
        w_wdata = '0;
      end
    endcase
  end

  // Every output is forced low while reset is asserted.
  always_comb begin
    dmem_address  = '0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    dmem_wmask    = 4'b0000;
    dmem_wdata    = '0;
    load_data_out = '0;
    mem_stall     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned    = 1'b0;
`endif
    if (rst) begin
      if (w_req) begin
        dmem_address = {addr_in[XLEN-1:2], 2'b00};
        dmem_read    = mem_read_in;
        dmem_write   = mem_write_in;
        if (mem_write_in) begin
          dmem_wmask = w_wmask;
          dmem_wdata = w_wdata;
        end
      end
      mem_stall = w_req & ~dmem_resp;
      if (r_state == HOLD) begin
        load_data_out = r_buf;
      end else if (w_done & mem_read_in) begin
        load_data_out = w_aligned;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned = w_mis;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_buf   <= '0;
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          if (w_done) begin
            r_buf   <= mem_read_in ? w_aligned : '0;
            r_state <= advance ? IDLE : HOLD;
          end else if (w_req) begin
            r_state <= WAIT;
          end
        end
        HOLD: begin
          if (advance) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected accesses, negedge monitor compares.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = 3'd0;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] store_data_in = 32'd0;
  logic        advance = 1'b0;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_resp = 1'b0;
  logic [31:0] load_data_out;
  logic        mem_stall;
  logic        misaligned_o;
  logic        tb_mis = 1'b0;

  mem_access_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .advance       (advance),
    .dmem_address  (dmem_address),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .load_data_out (load_data_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned    (misaligned_o),
`endif
    .mem_stall     (mem_stall)
  );

`ifndef MEM_MISALIGN_TRAP_EN
  assign misaligned_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] load;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  bit          exp_hold = 1'b0;
  logic [31:0] hold_val = 32'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: expected memory request and load result from byte-lane arithmetic.
  function automatic exp_t model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd);
    exp_t        e;
    int unsigned off, hi;
    logic [31:0] bv, hv;
    off = a % 4;
    hi  = (a / 2) % 2;
    e.addr = a - off;
    e.rd = ld;
    e.wr = !ld;
    e.wmask = 4'd0;
    e.wdata = 32'd0;
    e.load = 32'd0;
    bv = (rd >> (8 * off)) & 32'hFF;
    hv = (rd >> (16 * hi)) & 32'hFFFF;
    if (ld) begin
      case (f3)
        3'd0: e.load = (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
        3'd1: e.load = (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
        3'd2: e.load = rd;
        3'd4: e.load = bv;
        3'd5: e.load = hv;
        default: e.load = 32'd0;
      endcase
    end else begin
      case (f3)
        3'd0: begin e.wmask = 4'(1 << off); e.wdata = (sd & 32'hFF) << (8 * off); end
        3'd1: begin e.wmask = 4'(3 << (2 * hi)); e.wdata = (sd & 32'hFFFF) << (16 * hi); end
        3'd2: begin e.wmask = 4'hF; e.wdata = sd; end
        default: begin e.wmask = 4'd0; e.wdata = 32'd0; end
      endcase
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      exp_hold = 1'b0;
      chk("rst_address", dmem_address, 32'd0);
      chk("rst_read", 32'(dmem_read), 32'd0);
      chk("rst_write", 32'(dmem_write), 32'd0);
      chk("rst_wmask", 32'(dmem_wmask), 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_load", load_data_out, 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_misaligned", 32'(misaligned_o), 32'd0);
    end else begin
      chk("misaligned", 32'(misaligned_o), 32'(tb_mis));
      if (dmem_read || dmem_write) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_request", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q[0];
          chk("req_address", dmem_address, mon_e.addr);
          chk("req_read", 32'(dmem_read), 32'(mon_e.rd));
          chk("req_write", 32'(dmem_write), 32'(mon_e.wr));
          if (dmem_resp) begin
            void'(sb_q.pop_front());
            chk("resp_wmask", 32'(dmem_wmask), 32'(mon_e.wmask));
            chk("resp_wdata", dmem_wdata, mon_e.wdata);
            chk("resp_load", load_data_out, mon_e.load);
            chk("resp_stall", 32'(mem_stall), 32'd0);
            if (!advance) begin
              exp_hold = 1'b1;
              hold_val = mon_e.load;
            end
          end else begin
            chk("wait_stall", 32'(mem_stall), 32'd1);
            chk("wait_load", load_data_out, 32'd0);
          end
        end
      end else begin
        chk("idle_stall", 32'(mem_stall), 32'd0);
        chk("idle_address", dmem_address, 32'd0);
        chk("idle_wmask", 32'(dmem_wmask), 32'd0);
        chk("idle_wdata", dmem_wdata, 32'd0);
        if (exp_hold) begin
          chk("hold_load", load_data_out, hold_val);
          if (advance) exp_hold = 1'b0;
        end else begin
          chk("idle_load", load_data_out, 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0;
      mem_read_in = 1'($urandom_range(0, 1));
      mem_write_in = 1'($urandom_range(0, 1));
      funct3_in = 3'($urandom_range(0, 7));
      addr_in = $urandom;
      store_data_in = $urandom;
      dmem_rdata = $urandom;
      dmem_resp = 1'b0;
      advance = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    advance = 1'b0;
  endtask

  task automatic txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd,
                     input int lat, input int hold, input bit drop);
    bit mis;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = ((f3 % 4) == 1 && (a % 2) == 1) || ((f3 % 4) == 2 && (a % 4) != 0);
`endif
    valid_in = 1'b1;
    mem_read_in = ld;
    mem_write_in = !ld;
    funct3_in = f3;
    addr_in = a;
    store_data_in = sd;
    dmem_rdata = rd;
    if (mis) begin
      tb_mis = 1'b1;
      dmem_resp = 1'b0;
      advance = 1'b1;
      @(posedge clk); #1;
      tb_mis = 1'b0;
      valid_in = 1'b0;
      advance = 1'b0;
      return;
    end
    sb_q.push_back(model(ld, f3, a, sd, rd));
    dmem_resp = (lat == 0);
    advance = (lat == 0) && (hold == 0);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (drop) valid_in = 1'($urandom_range(0, 1));
      if (i == lat) begin
        dmem_resp = 1'b1;
        advance = (hold == 0);
      end
    end
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    dmem_rdata = $urandom;
    valid_in = 1'b1;
    if (hold > 0) begin
      for (int j = 1; j < hold; j++) begin
        advance = 1'b0;
        @(posedge clk); #1;
        dmem_rdata = $urandom;
      end
      advance = 1'b1;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    advance = 1'b0;
  endtask

  initial begin
    bit          ld;
    logic [2:0]  f3;
    logic [2:0]  lf3 [5];
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    txn(1'b1, 3'd2, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 2, 0, 1'b0);
    txn(1'b1, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 1'b0);
    txn(1'b1, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 1'b0);
    txn(1'b0, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 1, 0, 1'b0);
    txn(1'b1, 3'd5, 32'h0000_0002, 32'd0, 32'h5A5A_0000, 1, 4, 1'b0);
    idle(2);
    txn(1'b1, 3'd2, 32'h0000_0101, 32'd0, 32'hCAFE_F00D, 1, 0, 1'b0);
    txn(1'b0, 3'd0, 32'h0000_0301, 32'h0000_00A5, 32'd0, 0, 2, 1'b0);
    idle(1);

    for (int n = 0; n < 80; n++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 3));
      txn(ld, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 1));
    end

    // Reset pulled mid-access: the memory never answers this one.
    valid_in = 1'b1;
    mem_read_in = 1'b1;
    mem_write_in = 1'b0;
    funct3_in = 3'd2;
    addr_in = 32'h0000_3000;
    dmem_resp = 1'b0;
    sb_q.push_back(model(1'b1, 3'd2, 32'h0000_3000, 32'd0, 32'd0));
    @(posedge clk); #1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b1;
    idle(3);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage RV32I pipeline, sitting between the EX/MEM latch and the MEM/WB latch.
- Drives the data-memory request/response handshake, generates store byte masks and shifted write data, and aligns/extends load data into a word the MEM/WB latch captures.
- Buffers returned load data so a pipeline stall from elsewhere never causes a memory access to be reissued.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- valid_in  in  1  EX/MEM holds a valid instruction
- mem_read_in  in  1  instruction is a load
- mem_write_in  in  1  instruction is a store
- funct3_in  in  3  load/store width code
- addr_in  in  32  effective byte address from ALU
- store_data_in  in  32  rs2 value
- advance  in  1  pipeline load enable this cycle (MEM/WB latch loads)
- dmem_address  out  32  word-aligned address {addr_in[31:2],2'b00}
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  shifted store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  access complete
- load_data_out  out  32  aligned, extended load result
- mem_stall  out  1  freeze pipeline; access outstanding

Behaviour:
- Reset (rst low, async): state IDLE, buffer 0; every output 0 while rst is low.
- access = valid_in & (mem_read_in | mem_write_in).
- States: IDLE, WAIT, HOLD.
- IDLE:
  - If access, drive the request combinationally this cycle.
  - If dmem_resp arrives in the same cycle, the access completes with zero stall.
- WAIT: request held stable until dmem_resp.
- Request outputs are driven only in IDLE (with access) and WAIT.
- mem_stall = ((IDLE & access) | WAIT) & ~dmem_resp; always 0 in HOLD.
- Response cycle:
  - load_data_out bypasses the aligned dmem_rdata combinationally.
  - The aligned value is captured into the buffer.
  - Next state is IDLE if advance, else HOLD.
- IDLE & access & ~dmem_resp -> WAIT.
- HOLD:
  - No request; load_data_out comes from the buffer.
  - advance -> IDLE.
- Inputs are stable while mem_stall=1 (upstream latch frozen).
- valid_in dropping during WAIT does not abort the access; the handshake completes.
- Load alignment uses off = addr_in[1:0]:
  - LB 000: sign-extend byte[off].
  - LH 001: sign-extend half[addr_in[1]].
  - LW 010: full word.
  - LBU 100: zero-extend byte[off].
  - LHU 101: zero-extend half[addr_in[1]].
  - Other codes: 0.
- Stores:
  - SB 000: wmask 4'b0001<<off; wdata = byte shifted to lane off.
  - SH 001: wmask 4'b0011<<(2*addr_in[1]); wdata = half shifted by 16*addr_in[1].
  - SW 010: wmask 4'b1111.
  - Other codes: wmask 0.
- For non-store cycles, dmem_wmask = 0 and dmem_wdata = 0.
- Loads output load_data_out; for non-load cycles it is 0 (outside HOLD).
- Reset asserted during WAIT returns to IDLE immediately; the outstanding response is the memory's responsibility.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit), reset 0.
  - Asserted combinationally for a half access with addr_in[0]=1, or a word access with addr_in[1:0]!=0.
  - When asserted: no request is issued, mem_stall=0, load_data_out=0, FSM stays IDLE.
- Undefined:
  - Port absent.
  - Low address bits that violate alignment are ignored: LW/SW use the word; LH/SH use addr_in[1].

Decomposition:
- Shared package types:
  - rv32i_word
  - load_funct3_t / store_funct3_t enums (lb, lh, lw, lbu, lhu; sb, sh, sw)
  - mem_state_t enum {IDLE, WAIT, HOLD}
- One sub-module, load_align: pure combinational extraction and extension of dmem_rdata by funct3 and offset.
- Store masking stays inline.

Test Plan:
- LW at 0x0000_1004, dmem_resp 2 cycles after request, rdata 0xDEAD_BEEF, advance=1 on resp cycle:
  - mem_stall=1 for 2 cycles; dmem_address=0x1004.
  - load_data_out=0xDEAD_BEEF on resp cycle; FSM back to IDLE.
- LB at 0x103 with rdata 0x80FF_0000, zero-wait resp:
  - load_data_out=0xFFFF_FF80, mem_stall=0.
- LBU at 0x103 with the same data:
  - load_data_out=0x0000_0080.
- SH at 0x202, store_data_in=0x1234_ABCD:
  - dmem_write=1, wmask=4'b1100, dmem_address=0x200, wdata upper half=0xABCD.
- LHU at 0x002, rdata 0x5A5A_0000, resp with advance=0, then 3 cycles advance=0:
  - Enters HOLD; single request only; load_data_out=0x0000_5A5A throughout; advance=1 -> IDLE.
- Reset pulled low during WAIT:
  - Outputs 0 immediately; after release, FSM is IDLE and no request is driven without access.
  - With MEM_MISALIGN_TRAP_EN, LW at 0x101: misaligned=1, no request, mem_stall=0.
